rd_rotate_buf_ctrl: RTL and testbench

Sequencer for the 1024x256 write / 8192x32 read rotate buffer. The buffer is split into two ping-pong banks. Each bank holds one 64x64 tile of 32-bit pixels.
- Write side: packs incoming 256-bit pixel beats into the free bank.
- Read side: generates rotated 32-bit read addresses for the full bank and streams the pixels out with valid/ready backpressure.
- Sits between the DDR read burst path and the rotated pixel stream sink.

---
 rtl/rd_rotate_buf_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rd_rotate_buf_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_rotate_buf_ctrl.sv
// rd_rotate_buf_ctrl: ping-pong 64x64 tile rotate-buffer sequencer (256-bit beats in, rotated 32-bit pixels out).
// Optional macro ROT_MIRROR_EN adds rot_mirror, which flips the output column before the rotation mapping.
module rd_rotate_buf_ctrl #(
    parameter int WR_DATA_WIDTH = 256,
    parameter int RD_DATA_WIDTH = 32,
    parameter int TILE_LOG2     = 6,
    parameter int WR_ADDR_WIDTH = 2*TILE_LOG2+1-3,
    parameter int RD_ADDR_WIDTH = 2*TILE_LOG2+1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WR_DATA_WIDTH-1:0] in_data,
    input  logic [1:0]               rot_mode,
`ifdef ROT_MIRROR_EN
    input  logic                     rot_mirror,
`endif
    output logic                     buf_wr_en,
    output logic [WR_ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [WR_DATA_WIDTH-1:0] buf_wr_data,
    output logic [RD_ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [RD_DATA_WIDTH-1:0] buf_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RD_DATA_WIDTH-1:0] out_data,
    output logic                     out_last,
    output logic                     tile_done,
    output logic                     busy
);

    localparam int WCNT_W = WR_ADDR_WIDTH - 1;
    localparam int NPIX_W = 2 * TILE_LOG2;

    typedef enum logic [1:0] { R_IDLE, R_RUN, R_DRAIN } rd_state_e;

    logic [1:0]               r_bank_full;
    logic                     r_wbank;
    logic [WCNT_W-1:0]        r_wcnt;
    logic                     r_buf_wr_en;
    logic                     r_wr_last;
    logic [WR_ADDR_WIDTH-1:0] r_buf_wr_addr;
    logic [WR_DATA_WIDTH-1:0] r_buf_wr_data;

    rd_state_e                r_state;
    rd_state_e                w_state_nxt;
    logic                     r_rbank;
    logic [1:0]               r_mode;
    logic [NPIX_W-1:0]        r_n;
    logic                     r_inflight;
    logic                     r_inflight_last;

    logic [RD_DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]               r_fifo_last;
    logic                     r_fifo_wptr;
    logic                     r_fifo_rptr;
    logic [1:0]               r_fifo_cnt;

    logic                     w_accept;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_release;
    logic                     w_room;
    logic [TILE_LOG2-1:0]     w_i;
    logic [TILE_LOG2-1:0]     w_j;
    logic [TILE_LOG2-1:0]     w_row;
    logic [TILE_LOG2-1:0]     w_col;

    // ---------------- write side ----------------
    assign in_ready = !r_bank_full[r_wbank];
    assign w_accept = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_full   <= '0;
            r_wbank       <= 1'b0;
            r_wcnt        <= '0;
            r_buf_wr_en   <= 1'b0;
            r_wr_last     <= 1'b0;
            r_buf_wr_addr <= '0;
            r_buf_wr_data <= '0;
        end else begin
            r_buf_wr_en <= w_accept;
            r_wr_last   <= w_accept && (r_wcnt == '1);
            if (w_accept) begin
                r_buf_wr_addr <= {r_wbank, r_wcnt};
                r_buf_wr_data <= in_data;
                r_wcnt        <= r_wcnt + 1'b1;
                if (r_wcnt == '1)
                    r_wbank <= ~r_wbank;
            end
            // The bank becomes readable on the edge that writes its final beat into the buffer.
            if (r_buf_wr_en && r_wr_last)
                r_bank_full[r_buf_wr_addr[WR_ADDR_WIDTH-1]] <= 1'b1;
            if (w_release)
                r_bank_full[r_rbank] <= 1'b0;
        end
    end

    assign buf_wr_en   = r_buf_wr_en;
    assign buf_wr_addr = r_buf_wr_addr;
    assign buf_wr_data = r_buf_wr_data;

    // ---------------- read side ----------------
    assign out_valid = (r_fifo_cnt != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_room    = ({1'b0, r_fifo_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (r_bank_full[r_rbank])
                    w_state_nxt = R_RUN;
            end
            R_RUN: begin
                w_issue = w_room;
                if (w_room && (r_n == '1))
                    w_state_nxt = R_DRAIN;
            end
            R_DRAIN: begin
                if ((r_fifo_cnt == 2'd0) && !r_inflight) begin
                    w_release   = 1'b1;
                    w_state_nxt = R_IDLE;
                end
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

`ifdef ROT_MIRROR_EN
    logic r_mirror;
    always_ff @(posedge clk) begin
        if (rst)
            r_mirror <= 1'b0;
        else if ((r_state == R_IDLE) && (w_state_nxt == R_RUN))
            r_mirror <= rot_mirror;
    end
    assign w_j = r_mirror ? ~r_n[TILE_LOG2-1:0] : r_n[TILE_LOG2-1:0];
`else
    assign w_j = r_n[TILE_LOG2-1:0];
`endif
    assign w_i = r_n[NPIX_W-1:TILE_LOG2];

    // Inverting a 6-bit index is the same as 63 - index.
    always_comb begin
        w_row = w_i;
        w_col = w_j;
        case (r_mode)
            2'd1:    begin w_row = ~w_j; w_col = w_i;  end
            2'd2:    begin w_row = ~w_i; w_col = ~w_j; end
            2'd3:    begin w_row = w_j;  w_col = ~w_i; end
            default: begin w_row = w_i;  w_col = w_j;  end
        endcase
    end

    assign buf_rd_addr = {r_rbank, w_row, w_col};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= R_IDLE;
            r_rbank         <= 1'b0;
            r_mode          <= 2'd0;
            r_n             <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_wptr     <= 1'b0;
            r_fifo_rptr     <= 1'b0;
            r_fifo_cnt      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if ((r_state == R_IDLE) && (w_state_nxt == R_RUN))
                r_mode <= rot_mode;
            if (w_release)
                r_rbank <= ~r_rbank;
            if (w_issue) begin
                r_n             <= r_n + 1'b1;
                r_inflight_last <= (r_n == '1);
            end
            if (r_inflight)
                r_fifo_wptr <= ~r_fifo_wptr;
            if (w_pop)
                r_fifo_rptr <= ~r_fifo_rptr;
            case ({r_inflight, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // NOTE: FIFO payload is not reset; out_valid/out_last are qualified by the reset count instead.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_fifo_data[r_fifo_wptr] <= buf_rd_data;
            r_fifo_last[r_fifo_wptr] <= r_inflight_last;
        end
    end

    assign out_data  = r_fifo_data[r_fifo_rptr];
    assign out_last  = out_valid && r_fifo_last[r_fifo_rptr];
    assign tile_done = w_release;
    assign busy      = (|r_bank_full) || (r_state != R_IDLE);

endmodule

// File: tb/tb_rd_rotate_buf_ctrl.sv
// tb_rd_rotate_buf_ctrl: random/directed bench with a buffer RAM model and a tile-level rotation reference.
// Expected pixels are computed per completed tile from the rotation rules, then compared on every pop.
module tb_rd_rotate_buf_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [1:0]   rot_mode;
`ifdef ROT_MIRROR_EN
    logic         rot_mirror;
`endif
    logic         buf_wr_en;
    logic [9:0]   buf_wr_addr;
    logic [255:0] buf_wr_data;
    logic [12:0]  buf_rd_addr;
    logic [31:0]  buf_rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         tile_done;
    logic         busy;

    rd_rotate_buf_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .rot_mode    (rot_mode),
`ifdef ROT_MIRROR_EN
        .rot_mirror  (rot_mirror),
`endif
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_wr_data (buf_wr_data),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .tile_done   (tile_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Rotate buffer: 1024x256 write port, 8192x32 read port with one cycle of read latency.
    logic [31:0] mem [8192];
    always @(posedge clk) begin
        if (buf_wr_en)
            for (int k = 0; k < 8; k++) mem[buf_wr_addr*8 + k] <= buf_wr_data[32*k +: 32];
        buf_rd_data <= mem[buf_rd_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] d; logic last; } exp_t;
    typedef struct packed { logic [9:0] a; logic [255:0] d; } wr_t;

    exp_t        exp_q[$];
    wr_t         wq[$];
    logic [31:0] got_q[$];
    logic [31:0] acc_pix [4096];
    int          acc_cnt = 0;
    int          beat_total = 0;
    int          tiles_done = 0;
    int          rise_events = 0;
    bit          stall_prev = 0;
    logic [31:0] stall_data;
    logic        stall_last;
    bit          td_prev = 0;
    bit          lat_enable = 0;
    bit          lat_armed = 0;
    int          final_cyc = 0;
    int          lat_seen = -1;
    exp_t        e;
    wr_t         w;

    task automatic build_expected(input int mode, input bit mir);
        int i, j, r, c;
        for (int n = 0; n < 4096; n++) begin
            i = n / 64;
            j = mir ? 63 - (n % 64) : n % 64;
            case (mode)
                1:       begin r = 63 - j; c = i;      end
                2:       begin r = 63 - i; c = 63 - j; end
                3:       begin r = j;      c = 63 - i; end
                default: begin r = i;      c = j;      end
            endcase
            exp_q.push_back({acc_pix[r*64 + c], n == 4095});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            wq.delete();
            acc_cnt    = 0;
            beat_total = 0;
            stall_prev = 0;
            td_prev    = 0;
            lat_armed  = 0;
        end else begin
            if (wq.size() > 0) begin
                w = wq.pop_front();
                check("wr_en", buf_wr_en, 1);
                check("wr_addr", buf_wr_addr, w.a);
                check("wr_data", buf_wr_data, w.d);
            end else if (buf_wr_en) begin
                check("wr_en_spurious", buf_wr_en, 0);
            end
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_data);
                check("stall_last", out_last, stall_last);
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
            if (td_prev) begin
                rise_events++;
                check("in_ready_after_done", in_ready, 1);
            end
            td_prev = tile_done && !in_ready;
            if (tile_done) tiles_done++;
            if (lat_armed && out_valid) begin
                lat_seen  = cyc - final_cyc;
                lat_armed = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.last);
                end
                got_q.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < 8; k++) acc_pix[acc_cnt + k] = in_data[32*k +: 32];
                acc_cnt += 8;
                wq.push_back({10'(beat_total % 1024), in_data});
                beat_total++;
                if (acc_cnt == 4096) begin
`ifdef ROT_MIRROR_EN
                    build_expected(int'(rot_mode), rot_mirror);
`else
                    build_expected(int'(rot_mode), 1'b0);
`endif
                    acc_cnt = 0;
                    if (lat_enable) begin
                        final_cyc = cyc;
                        lat_armed = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit ready_mode = 0;
    bit ready_level = 1;
    int tag_ctr = 0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // kind 0: pixel = raster index; 1: random; 2: (tile tag << 16) | raster index
    task automatic send_tile(input int kind, input int gap_pct);
        logic [255:0] beat;
        logic [31:0]  p;
        int           tmo;
        tag_ctr++;
        for (int b = 0; b < 512; b++) begin
            for (int k = 0; k < 8; k++) begin
                case (kind)
                    0:       p = 32'(b*8 + k);
                    1:       p = $urandom;
                    default: p = 32'((tag_ctr << 16) | (b*8 + k));
                endcase
                beat[32*k +: 32] = p;
            end
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = beat;
            tmo      = 0;
            while (!in_ready) begin
                @(posedge clk);
                #1;
                tmo++;
                if (tmo > 20000) begin
                    fail_timeout("send_beat");
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(exp_q.size() == 0 && !busy)) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 40000) begin
                fail_timeout("wait_idle");
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_tile_done"}, tile_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wr_en"}, buf_wr_en, 0);
        check({tag, "_wr_addr"}, buf_wr_addr, 0);
        check({tag, "_rd_addr"}, buf_rd_addr, 0);
    endtask

    initial begin
        int base, td_base, t0, t;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        rot_mode = 2'd0;
`ifdef ROT_MIRROR_EN
        rot_mirror = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Raster tile, 0 degrees, with first-output latency measurement.
        got_q.delete();
        lat_enable = 1;
        send_tile(0, 0);
        wait_idle();
        lat_enable = 0;
        check("latency", lat_seen, 5);
        check("m0_count", got_q.size(), 4096);
        check("m0_first", got_q[0], 0);
        check("m0_second", got_q[1], 1);
        check("m0_last", got_q[4095], 4095);
        check("m0_tiles_done", tiles_done, 1);

        for (int m = 1; m < 4; m++) begin
            rot_mode = 2'(m);
            got_q.delete();
            send_tile(0, 0);
            wait_idle();
            check("mode_count", got_q.size(), 4096);
            case (m)
                1: begin
                    check("m1_first", got_q[0], 4032);
                    check("m1_second", got_q[1], 3968);
                    check("m1_third", got_q[2], 3904);
                    check("m1_idx64", got_q[64], 4033);
                    check("m1_last", got_q[4095], 63);
                end
                2: begin
                    check("m2_first", got_q[0], 4095);
                    check("m2_last", got_q[4095], 0);
                end
                default: begin
                    check("m3_first", got_q[0], 63);
                    check("m3_second", got_q[1], 127);
                    check("m3_last", got_q[4095], 4032);
                end
            endcase
        end

        // Three tiles back-to-back with the sink stalled.
        rot_mode    = 2'd0;
        ready_level = 0;
        got_q.delete();
        td_base = tiles_done;
        base    = beat_total;
        t0      = tag_ctr + 1;
        fork
            begin
                send_tile(2, 0);
                send_tile(2, 0);
                send_tile(2, 0);
            end
            begin
                t = 0;
                while ((beat_total - base) < 1024 && t < 20000) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                repeat (50) @(posedge clk);
                #1;
                check("blocked_beats", beat_total - base, 1024);
                check("blocked_in_ready", in_ready, 0);
                check("blocked_busy", busy, 1);
                check("blocked_out_valid", out_valid, 1);
                ready_level = 1;
            end
        join
        wait_idle();
        check("b2b_tiles_done", tiles_done - td_base, 3);
        check("b2b_count", got_q.size(), 12288);
        check("b2b_tile0_first", got_q[0], t0 << 16);
        check("b2b_tile1_first", got_q[4096], (t0 + 1) << 16);
        check("b2b_tile2_last", got_q[12287], ((t0 + 2) << 16) | 4095);
        check("b2b_ready_rise_seen", rise_events > 0, 1);

        // Random data, random mode, random sink backpressure and source gaps.
        ready_mode = 1;
        rot_mode   = 2'($urandom_range(0, 3));
        td_base    = tiles_done;
        send_tile(1, 30);
        send_tile(1, 30);
        wait_idle();
        ready_mode = 0;
        check("rand_tiles_done", tiles_done - td_base, 2);

        // Reset in the middle of a tile read, then a fresh tile.
        rot_mode = 2'd0;
        got_q.delete();
        td_base = tiles_done;
        send_tile(0, 0);
        t = 0;
        while (got_q.size() < 2000 && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("midreset_reached", got_q.size() >= 2000, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("midreset");
        check("midreset_no_done", tiles_done - td_base, 0);
        rot_mode = 2'd2;
        got_q.delete();
        send_tile(2, 0);
        wait_idle();
        check("fresh_count", got_q.size(), 4096);
        check("fresh_first", got_q[0], (tag_ctr << 16) | 4095);
        check("fresh_last", got_q[4095], tag_ctr << 16);
        check("fresh_tiles_done", tiles_done - td_base, 1);
        check("end_busy", busy, 0);
        check("end_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        failures++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
